// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array: default widths, drain hold state,
// and the per-mode saturation limits used by the accumulators.
package sa_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int LIMIT_WIDTH    = 128;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

  // Limits are computed wide and cut to the accumulator width by the caller.
  function automatic logic [LIMIT_WIDTH-1:0] sat_hi(input logic signed_mode, input int width);
    logic [LIMIT_WIDTH-1:0] one;
    one = {{(LIMIT_WIDTH-1){1'b0}}, 1'b1};
    if (signed_mode) sat_hi = (one << (width - 1)) - one;
    else             sat_hi = (one << width) - one;
  endfunction

  function automatic logic [LIMIT_WIDTH-1:0] sat_lo(input logic signed_mode, input int width);
    logic [LIMIT_WIDTH-1:0] one;
    one = {{(LIMIT_WIDTH-1){1'b0}}, 1'b1};
    if (signed_mode) sat_lo = one << (width - 1);
    else             sat_lo = '0;
  endfunction

endpackage

// File: rtl/sa_sat_acc.sv
// Combinational saturating accumulate: extends a product to the accumulator
// width, adds it, and clips to the signed or unsigned range.
module sa_sat_acc
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                    signed_mode,
  input  logic [ACC_WIDTH-1:0]    acc,
  input  logic [2*DATA_WIDTH-1:0] prod,
  output logic [ACC_WIDTH-1:0]    sum_clip,
  output logic                    sat
);

  localparam logic [ACC_WIDTH-1:0] HI_S = ACC_WIDTH'(sat_hi(1'b1, ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] LO_S = ACC_WIDTH'(sat_lo(1'b1, ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] HI_U = ACC_WIDTH'(sat_hi(1'b0, ACC_WIDTH));

  logic [ACC_WIDTH:0] acc_x;
  logic [ACC_WIDTH:0] prod_x;
  logic [ACC_WIDTH:0] sum_x;

  // One guard bit is enough: signed overflow shows as the top two bits
  // disagreeing, unsigned overflow as a carry out.
  always_comb begin
    acc_x    = {signed_mode & acc[ACC_WIDTH-1], acc};
    prod_x   = {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){signed_mode & prod[2*DATA_WIDTH-1]}}, prod};
    sum_x    = acc_x + prod_x;
    sum_clip = sum_x[ACC_WIDTH-1:0];
    sat      = 1'b0;
    if (signed_mode) begin
      if (sum_x[ACC_WIDTH] != sum_x[ACC_WIDTH-1]) begin
        sat      = 1'b1;
        sum_clip = sum_x[ACC_WIDTH] ? LO_S : HI_S;
      end
    end else if (sum_x[ACC_WIDTH]) begin
      sat      = 1'b1;
      sum_clip = HI_U;
    end
  end

endmodule

// File: rtl/systolic_pe_acc.sv
// Output-stationary systolic PE: forwards operands east/south, runs a two-stage
// MAC into a saturating accumulator, and hands finished tiles to a drain chain.
module systolic_pe_acc
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  signed_mode,
  input  logic [DATA_WIDTH-1:0] in_west_data,
  input  logic                  in_west_valid,
  input  logic                  in_west_last,
  input  logic [DATA_WIDTH-1:0] in_north_data,
  input  logic                  in_north_valid,
  output logic [DATA_WIDTH-1:0] out_east_data,
  output logic                  out_east_valid,
  output logic                  out_east_last,
  output logic [DATA_WIDTH-1:0] out_south_data,
  output logic                  out_south_valid,
  input  logic                  drain_load,
  input  logic                  drain_shift,
  input  logic [ACC_WIDTH-1:0]  drain_in,
  input  logic                  drain_in_valid,
  output logic [ACC_WIDTH-1:0]  drain_out,
  output logic                  drain_out_valid,
  output logic                  sat_flag,
  output logic                  overrun_flag,
  input  logic                  clr_flags
);

  if (ACC_WIDTH < 2*DATA_WIDTH || ACC_WIDTH >= LIMIT_WIDTH) begin : g_width_check
    $error("systolic_pe_acc: ACC_WIDTH must be >= 2*DATA_WIDTH and < LIMIT_WIDTH");
  end

  logic [2*DATA_WIDTH-1:0] a_x;
  logic [2*DATA_WIDTH-1:0] b_x;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    fire;

  logic [2*DATA_WIDTH-1:0] p_reg;
  logic                    p_valid;
  logic                    p_last;

  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    hold;
  logic [ACC_WIDTH-1:0]    sum_clip;
  logic                    sat_hit;
  logic                    accept;
  logic                    commit;
  logic                    load;
  logic                    overrun_set;

  hold_state_e             state_q;
  hold_state_e             state_d;

  // Low half of a double-width product is correct for both modes once the
  // operands are sign- or zero-extended, so one multiplier serves both.
  always_comb begin
    a_x  = {{DATA_WIDTH{signed_mode & in_west_data[DATA_WIDTH-1]}}, in_west_data};
    b_x  = {{DATA_WIDTH{signed_mode & in_north_data[DATA_WIDTH-1]}}, in_north_data};
    prod = a_x * b_x;
  end

  assign fire   = en & in_west_valid & in_north_valid;
  assign accept = en & p_valid;
  assign commit = accept & p_last;
  assign load   = en & drain_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_east_data   <= '0;
      out_east_valid  <= 1'b0;
      out_east_last   <= 1'b0;
      out_south_data  <= '0;
      out_south_valid <= 1'b0;
    end else if (en) begin
      out_east_data   <= in_west_data;
      out_east_valid  <= in_west_valid;
      out_east_last   <= in_west_last;
      out_south_data  <= in_north_data;
      out_south_valid <= in_north_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg   <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (en) begin
      p_valid <= fire;
      p_last  <= in_west_last & fire;
      if (fire) p_reg <= prod;
    end
  end

  sa_sat_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat_acc (
    .signed_mode (signed_mode),
    .acc         (acc),
    .prod        (p_reg),
    .sum_clip    (sum_clip),
    .sat         (sat_hit)
  );

  // The last product of a tile goes to hold and restarts acc at zero, so the
  // next tile can follow without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      hold <= '0;
    end else begin
      if (accept) acc <= p_last ? '0 : sum_clip;
      if (commit) hold <= sum_clip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    overrun_set = 1'b0;
    unique case (state_q)
      EMPTY: if (commit) state_d = FULL;
      FULL: begin
        if (commit)    overrun_set = ~load;
        else if (load) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_out       <= '0;
      drain_out_valid <= 1'b0;
    end else if (load) begin
      drain_out       <= hold;
      drain_out_valid <= (state_q == FULL);
    end else if (en & drain_shift) begin
      drain_out       <= drain_in;
      drain_out_valid <= drain_in_valid;
    end
  end

  // A set event in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag     <= 1'b0;
      overrun_flag <= 1'b0;
    end else if (en) begin
      sat_flag     <= (accept & sat_hit) | (sat_flag & ~clr_flags);
      overrun_flag <= overrun_set | (overrun_flag & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Self-checking bench: a 3-PE drain column with default widths plus an
// 8/16-bit PE for saturation corners; tile results go through a scoreboard.
module tb_systolic_pe_acc;

  logic clk;
  logic rst;
  logic en;
  logic sm;
  logic drain_load;
  logic drain_shift;
  logic clr_flags;

  logic [15:0] wd [3];
  logic [15:0] nd [3];
  logic        wv [3];
  logic        wl [3];
  logic        nv [3];
  logic [15:0] ed [3];
  logic [15:0] sd [3];
  logic        ev [3];
  logic        el [3];
  logic        sv [3];
  logic [39:0] dout [3];
  logic        dvld [3];
  logic [39:0] din [3];
  logic        dinv [3];
  logic        satf [3];
  logic        ovrf [3];

  logic [7:0]  w8, n8, ed8, sd8;
  logic        wv8, wl8, nv8, sm8, dl8;
  logic        ev8, el8, sv8, dv8, sat8, ovr8;
  logic [15:0] dout8;

  int          checks;
  int          failures;
  longint      model_acc;
  logic [39:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_col
    if (i == 0) begin : g_top
      assign din[i]  = '0;
      assign dinv[i] = 1'b0;
    end else begin : g_below
      assign din[i]  = dout[i-1];
      assign dinv[i] = dvld[i-1];
    end

    systolic_pe_acc u_pe (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .signed_mode     (sm),
      .in_west_data    (wd[i]),
      .in_west_valid   (wv[i]),
      .in_west_last    (wl[i]),
      .in_north_data   (nd[i]),
      .in_north_valid  (nv[i]),
      .out_east_data   (ed[i]),
      .out_east_valid  (ev[i]),
      .out_east_last   (el[i]),
      .out_south_data  (sd[i]),
      .out_south_valid (sv[i]),
      .drain_load      (drain_load),
      .drain_shift     (drain_shift),
      .drain_in        (din[i]),
      .drain_in_valid  (dinv[i]),
      .drain_out       (dout[i]),
      .drain_out_valid (dvld[i]),
      .sat_flag        (satf[i]),
      .overrun_flag    (ovrf[i]),
      .clr_flags       (clr_flags)
    );
  end

  systolic_pe_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16)) u_pe8 (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .signed_mode     (sm8),
    .in_west_data    (w8),
    .in_west_valid   (wv8),
    .in_west_last    (wl8),
    .in_north_data   (n8),
    .in_north_valid  (nv8),
    .out_east_data   (ed8),
    .out_east_valid  (ev8),
    .out_east_last   (el8),
    .out_south_data  (sd8),
    .out_south_valid (sv8),
    .drain_load      (dl8),
    .drain_shift     (1'b0),
    .drain_in        (16'd0),
    .drain_in_valid  (1'b0),
    .drain_out       (dout8),
    .drain_out_valid (dv8),
    .sat_flag        (sat8),
    .overrun_flag    (ovr8),
    .clr_flags       (clr_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one operand pair into the bottom PE and keeps the reference sum.
  task automatic applyStimulus(input int a, input int b, input bit last);
    wd[2] = a[15:0];
    nd[2] = b[15:0];
    wv[2] = 1'b1;
    nv[2] = 1'b1;
    wl[2] = last;
    model_acc += longint'(a) * longint'(b);
    if (last) begin
      exp_q.push_back(model_acc[39:0]);
      model_acc = 0;
    end
    tick();
    wv[2] = 1'b0;
    nv[2] = 1'b0;
    wl[2] = 1'b0;
  endtask

  task automatic drainCheck(input string tag);
    logic [39:0] exp_v;
    drain_load = 1'b1;
    tick();
    drain_load = 1'b0;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checkOutput({tag, "_vld"}, 64'(dvld[2]), 64'd1);
    checkOutput({tag, "_data"}, 64'(dout[2]), 64'(exp_v));
  endtask

  task automatic shiftCheck(input string tag, input bit exp_valid);
    logic [39:0] exp_v;
    drain_shift = 1'b1;
    tick();
    drain_shift = 1'b0;
    exp_v = '0;
    if (exp_valid) exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checkOutput({tag, "_vld"}, 64'(dvld[2]), 64'(exp_valid));
    checkOutput({tag, "_data"}, 64'(dout[2]), 64'(exp_v));
  endtask

  task automatic applyStim8(input logic [7:0] a, input logic [7:0] b, input bit last);
    w8 = a; n8 = b; wv8 = 1'b1; nv8 = 1'b1; wl8 = last;
    tick();
    wv8 = 1'b0; nv8 = 1'b0; wl8 = 1'b0;
  endtask

  task automatic load8();
    dl8 = 1'b1;
    tick();
    dl8 = 1'b0;
  endtask

  task automatic clearFlags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    model_acc = 0;
    rst = 1'b1; en = 1'b1; sm = 1'b1;
    drain_load = 1'b0; drain_shift = 1'b0; clr_flags = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wd[i] = '0; nd[i] = '0; wv[i] = 1'b0; wl[i] = 1'b0; nv[i] = 1'b0;
    end
    w8 = '0; n8 = '0; wv8 = 1'b0; wl8 = 1'b0; nv8 = 1'b0; sm8 = 1'b0; dl8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    checkOutput("rst_dout", 64'(dout[2]), 64'd0);
    checkOutput("rst_dvld", 64'(dvld[2]), 64'd0);
    checkOutput("rst_east_vld", 64'(ev[2]), 64'd0);
    checkOutput("rst_sat", 64'(satf[2]), 64'd0);
    checkOutput("rst_ovr", 64'(ovrf[2]), 64'd0);

    // Forwarding with only one side valid: copies, but no MAC.
    wd[2] = 16'h1234; wv[2] = 1'b1; nd[2] = 16'h0abc; nv[2] = 1'b0;
    tick();
    wv[2] = 1'b0;
    checkOutput("fwd_east", 64'(ed[2]), 64'h1234);
    checkOutput("fwd_east_vld", 64'(ev[2]), 64'd1);
    checkOutput("fwd_south", 64'(sd[2]), 64'h0abc);
    checkOutput("fwd_south_vld", 64'(sv[2]), 64'd0);
    tick();
    tick();
    drain_load = 1'b1;
    tick();
    drain_load = 1'b0;
    checkOutput("onesided_no_commit", 64'(dvld[2]), 64'd0);

    // Signed tile k=3 -> 27
    applyStimulus(-3, 4, 0);
    applyStimulus(5, 5, 0);
    applyStimulus(-2, -7, 1);
    tick();
    drainCheck("tile_signed");
    checkOutput("tile_signed_ovr", 64'(ovrf[2]), 64'd0);

    // Back-to-back tiles without a load in between -> overrun
    applyStimulus(1, 2, 0);
    applyStimulus(3, 4, 1);
    applyStimulus(5, 6, 1);
    tick();
    checkOutput("b2b_ovr", 64'(ovrf[2]), 64'd1);
    // The first tile was overwritten in hold and never reaches the drain.
    void'(exp_q.pop_front());
    drainCheck("b2b_second");
    clearFlags();
    checkOutput("b2b_ovr_clr", 64'(ovrf[2]), 64'd0);

    // Load on the same edge as the next commit
    applyStimulus(1, 2, 0);
    applyStimulus(3, 4, 1);
    tick();
    applyStimulus(5, 6, 1);
    drainCheck("simul_old");
    checkOutput("simul_ovr", 64'(ovrf[2]), 64'd0);
    drainCheck("simul_new");

    // Three-PE column: 7, 8, 9 drain out bottom-first
    for (int i = 0; i < 3; i++) begin
      wd[i] = 16'(7 + i); nd[i] = 16'd1; wv[i] = 1'b1; nv[i] = 1'b1; wl[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      wv[i] = 1'b0; nv[i] = 1'b0; wl[i] = 1'b0;
    end
    exp_q.push_back(40'd9);
    exp_q.push_back(40'd8);
    exp_q.push_back(40'd7);
    tick();
    drainCheck("chain_load");
    shiftCheck("chain_s1", 1'b1);
    shiftCheck("chain_s2", 1'b1);
    shiftCheck("chain_s3", 1'b0);

    // Stall for 4 cycles mid-tile: frozen forwarding, same final result
    applyStimulus(-3, 4, 0);
    applyStimulus(5, 5, 0);
    en = 1'b0;
    wd[2] = 16'h7777; nd[2] = 16'h0003; wv[2] = 1'b1; nv[2] = 1'b1;
    drain_load = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    drain_load = 1'b0; wv[2] = 1'b0; nv[2] = 1'b0;
    checkOutput("stall_east_frozen", 64'(ed[2]), 64'd5);
    checkOutput("stall_dout_frozen", 64'(dout[2]), 64'd0);
    en = 1'b1;
    applyStimulus(-2, -7, 1);
    tick();
    drainCheck("stall_tile");

    // Asynchronous reset mid-tile discards everything
    applyStimulus(100, 100, 0);
    applyStimulus(1, 1, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_dout", 64'(dout[2]), 64'd0);
    checkOutput("midrst_dvld", 64'(dvld[2]), 64'd0);
    checkOutput("midrst_east", 64'(ed[2]), 64'd0);
    model_acc = 0;
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(2, 3, 1);
    tick();
    drainCheck("after_rst");

    // 8/16-bit PE: unsigned clip to 65535
    sm8 = 1'b0;
    applyStim8(8'd255, 8'd255, 0);
    applyStim8(8'd255, 8'd255, 1);
    tick();
    load8();
    checkOutput("u8_sat_val", 64'(dout8), 64'hffff);
    checkOutput("u8_sat_vld", 64'(dv8), 64'd1);
    checkOutput("u8_sat_flag", 64'(sat8), 64'd1);
    clearFlags();
    checkOutput("u8_sat_clr", 64'(sat8), 64'd0);

    // Signed positive clip: (-128)*(-128) twice = 32768 -> 32767
    sm8 = 1'b1;
    applyStim8(8'h80, 8'h80, 0);
    applyStim8(8'h80, 8'h80, 1);
    tick();
    load8();
    checkOutput("s8_pos_clip", 64'(dout8), 64'h7fff);
    checkOutput("s8_pos_flag", 64'(sat8), 64'd1);
    clearFlags();

    // Signed negative clip: (-128)*127 three times = -48768 -> -32768
    applyStim8(8'h80, 8'h7f, 0);
    applyStim8(8'h80, 8'h7f, 0);
    applyStim8(8'h80, 8'h7f, 1);
    tick();
    load8();
    checkOutput("s8_neg_clip", 64'(dout8), 64'h8000);
    checkOutput("s8_neg_flag", 64'(sat8), 64'd1);

    // In-range signed tile leaves the flag clear: (-5)*3 + 2*2 = -11
    clearFlags();
    applyStim8(8'hfb, 8'h03, 0);
    applyStim8(8'h02, 8'h02, 1);
    tick();
    load8();
    checkOutput("s8_small", 64'(dout8), 64'hfff5);
    checkOutput("s8_small_flag", 64'(sat8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
